lsu_seq: RTL and testbench

- Load/store sequencer sitting directly upstream of the data memory: it accepts one memory request at a time from the ARM datapath.
- It translates the request into the memory's we/be/a/wd encoding, captures read data, and returns one response per request.
- It detects misaligned accesses and reports them as faults.
- It can split an upper-halfword access into two byte-lane accesses.

---
 rtl/lsu_pkg.sv | 66 ++++++
 rtl/lsu_be_enc.sv | 55 +++++
 rtl/lsu_seq.sv | 136 +++++++++++++
 tb/tb_lsu_seq.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, byte-enable codes and op helpers for the load/store sequencer.
// Build with LSU_SPLIT_HALF_EN to split upper-halfword accesses into two byte lanes.
package lsu_pkg;

  typedef enum logic [2:0] {
    LDR   = 3'd0,
    LDRB  = 3'd1,
    LDRH  = 3'd2,
    LDRSB = 3'd3,
    LDRSH = 3'd4,
    STR   = 3'd5,
    STRB  = 3'd6,
    STRH  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    WD_WORD  = 2'd0,
    WD_BYTE0 = 2'd1,
    WD_BYTE1 = 2'd2
  } wd_sel_e;

  localparam logic [3:0] BE_WORD  = 4'b0000;
  localparam logic [3:0] BE_HALF  = 4'b0011;
  localparam logic [3:0] BE_SHALF = 4'b0100;
  localparam logic [3:0] BE_BYTE  = 4'b1000;
  localparam logic [3:0] BE_SBYTE = 4'b1100;

`ifdef LSU_SPLIT_HALF_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  function automatic logic is_store(lsu_op_e op);
    return op inside {STR, STRB, STRH};
  endfunction

  function automatic logic is_signed(lsu_op_e op);
    return op inside {LDRSB, LDRSH};
  endfunction

  function automatic logic is_word(lsu_op_e op);
    return op inside {LDR, STR};
  endfunction

  function automatic logic is_half(lsu_op_e op);
    return op inside {LDRH, LDRSH, STRH};
  endfunction

  function automatic logic misaligned(lsu_op_e op, logic [1:0] lo);
    logic f;
    f = 1'b0;
    if (is_word(op) && lo != 2'b00) f = 1'b1;
    if (is_half(op) && lo[0]) f = 1'b1;
    if (is_half(op) && lo[1] && !SPLIT_EN) f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/lsu_be_enc.sv
// Maps a latched op and low address bits to the memory lane code,
// the write-data byte select and the fault / split flags.
module lsu_be_enc
  import lsu_pkg::*;
(
  input  lsu_op_e    op_i,
  input  logic [1:0] addr_lo_i,
  input  logic       phase_i,
  output logic [3:0] be_o,
  output logic       fault_o,
  output logic       split_o,
  output wd_sel_e    wd_sel_o
);

`ifndef LSU_SPLIT_HALF_EN
  logic unused_phase;
  assign unused_phase = phase_i;
`endif

  always_comb begin
    be_o     = BE_WORD;
    split_o  = 1'b0;
    wd_sel_o = WD_WORD;
    fault_o  = misaligned(op_i, addr_lo_i);
    unique case (1'b1)
      is_word(op_i): begin
        be_o = BE_WORD;
      end
      is_half(op_i): begin
        if (addr_lo_i[1]) begin
`ifdef LSU_SPLIT_HALF_EN
          // upper half goes out as lane 2 then lane 3
          split_o  = 1'b1;
          be_o     = BE_BYTE | {3'b001, phase_i};
          wd_sel_o = phase_i ? WD_BYTE1 : WD_BYTE0;
`else
          be_o     = BE_WORD;
`endif
        end else begin
          be_o = is_signed(op_i) ? BE_SHALF : BE_HALF;
        end
      end
      default: begin
        be_o     = (is_signed(op_i) ? BE_SBYTE : BE_BYTE)
                 | {2'b00, addr_lo_i};
        wd_sel_o = WD_BYTE0;
      end
    endcase
    if (fault_o) begin
      be_o    = BE_WORD;
      split_o = 1'b0;
    end
  end

endmodule

// File: rtl/lsu_seq.sv
// Load/store sequencer: one request at a time into the data memory,
// one response per request, misaligned accesses answered as faults.
module lsu_seq
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  lsu_state_e        state_q, state_d;
  lsu_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [7:0]        hi_q, hi_d;

  logic [3:0]        enc_be;
  logic              enc_fault;
  logic              enc_split;
  wd_sel_e           enc_wd_sel;
  logic              we_raw;
  logic              split_ld;
  logic [DATA_W-1:0] ld_res;

  lsu_be_enc u_be_enc (
    .op_i      (op_q),
    .addr_lo_i (addr_q[1:0]),
    .phase_i   (state_q == ACC2),
    .be_o      (enc_be),
    .fault_o   (enc_fault),
    .split_o   (enc_split),
    .wd_sel_o  (enc_wd_sel)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= LDR;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      cap_q   <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
      cap_q   <= cap_d;
      hi_q    <= hi_d;
    end
  end

  // split loads assemble the halfword here; others arrive pre-extended
  assign split_ld = is_half(op_q) && addr_q[1];
  assign ld_res   = split_ld
                  ? {{16{is_signed(op_q) & hi_q[7]}}, hi_q, cap_q[7:0]}
                  : cap_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fault_d    = fault_q;
    cap_d      = cap_q;
    hi_d       = hi_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_fault = 1'b0;
    resp_rdata = '0;
    we_raw     = 1'b0;
    mem_be     = BE_WORD;
    mem_a      = '0;
    mem_wd     = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = lsu_op_e'(req_op);
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cap_d   = '0;
          hi_d    = '0;
          fault_d = misaligned(lsu_op_e'(req_op), req_addr[1:0]);
          state_d = fault_d ? RESP : ACC1;
        end
      end
      ACC1, ACC2: begin
        mem_a  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_be = enc_be;
        we_raw = is_store(op_q) && !enc_fault;
        unique case (enc_wd_sel)
          WD_BYTE0: mem_wd = {24'b0, wdata_q[7:0]};
          WD_BYTE1: mem_wd = {24'b0, wdata_q[15:8]};
          default:  mem_wd = wdata_q;
        endcase
        if (state_q == ACC1) begin
          if (!is_store(op_q)) cap_d = mem_rd;
          state_d = enc_split ? ACC2 : RESP;
        end else begin
          if (!is_store(op_q)) hi_d = mem_rd[7:0];
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault_q;
        if (!fault_q && !is_store(op_q)) resp_rdata = ld_res;
        state_d = IDLE;
      end
    endcase
  end

  // no write may reach memory while reset is asserted
  assign mem_we = we_raw & reset_n;

endmodule

// File: tb/tb_lsu_seq.sv
// Directed plus randomized bench for lsu_seq against a byte-array memory model.
module tb_lsu_seq;

  localparam logic [2:0] T_LDR = 3'd0, T_LDRB = 3'd1, T_LDRH = 3'd2;
  localparam logic [2:0] T_LDRSB = 3'd3, T_LDRSH = 3'd4, T_STR = 3'd5;
  localparam logic [2:0] T_STRB = 3'd6, T_STRH = 3'd7;

`ifdef LSU_SPLIT_HALF_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  function automatic logic [31:0] init_word(int i);
    return (i * 32'h9E3779B1) ^ 32'hA5A55A5A;
  endfunction

  // memory device: word array decoding the lane code
  logic [31:0] mem [0:255];
  bit          mem_init_done = 1'b0;

  always_comb begin
    logic [31:0] w;
    logic [7:0]  b;
    w = mem[mem_a[9:2]];
    b = w[8*mem_be[1:0] +: 8];
    if (mem_be[3])
      mem_rd = mem_be[2] ? {{24{b[7]}}, b} : {24'b0, b};
    else if (mem_be == 4'b0011)
      mem_rd = {16'b0, w[15:0]};
    else if (mem_be == 4'b0100)
      mem_rd = {{16{w[15]}}, w[15:0]};
    else
      mem_rd = w;
  end

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (mem_we) begin
      if (mem_be[3])
        mem[mem_a[9:2]][8*mem_be[1:0] +: 8] <= mem_wd[7:0];
      else if (mem_be == 4'b0011)
        mem[mem_a[9:2]][15:0] <= mem_wd[15:0];
      else
        mem[mem_a[9:2]] <= mem_wd;
    end
  end

  // reference: plain byte-addressed little-endian memory
  logic [7:0] ref_b [0:1023];

  function automatic bit op_st(logic [2:0] op);
    return op >= T_STR;
  endfunction
  function automatic bit op_word(logic [2:0] op);
    return op == T_LDR || op == T_STR;
  endfunction
  function automatic bit op_half(logic [2:0] op);
    return op == T_LDRH || op == T_LDRSH || op == T_STRH;
  endfunction
  function automatic bit op_sgn(logic [2:0] op);
    return op == T_LDRSB || op == T_LDRSH;
  endfunction

  function automatic bit exp_fault(logic [2:0] op, int a);
    if (op_word(op)) return (a % 4) != 0;
    if (op_half(op)) return (a % 2) != 0 || ((a % 4) == 2 && !SPLIT);
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] op, int a);
    logic [7:0] b0, b1;
    b0 = ref_b[a];
    b1 = ref_b[(a + 1) % 1024];
    case (op)
      T_LDR:   return {ref_b[a+3], ref_b[a+2], b1, b0};
      T_LDRB:  return {24'b0, b0};
      T_LDRSB: return {{24{b0[7]}}, b0};
      T_LDRH:  return {16'b0, b1, b0};
      default: return {{16{b1[7]}}, b1, b0};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold,
                        output logic [31:0] rd);
    int n, k, lat, nacc, ai;
    bit f, split;
    logic [3:0]  ebe [2];
    logic [31:0] ewd [2];
    logic [31:0] erd;
    ai    = int'(a[9:0]);
    f     = exp_fault(op, ai);
    split = op_half(op) && (ai % 4) == 2 && !f;
    ebe[1] = 4'b0000;
    ewd[1] = 32'h0;
    if (f) begin
      lat = 1; nacc = 0;
      ebe[0] = 4'b0000; ewd[0] = 32'h0;
    end else if (split) begin
      lat = 3; nacc = 2;
      ebe[0] = 4'b1010; ewd[0] = {24'b0, wd[7:0]};
      ebe[1] = 4'b1011; ewd[1] = {24'b0, wd[15:8]};
    end else begin
      lat = 2; nacc = 1;
      if (op_word(op)) begin
        ebe[0] = 4'b0000; ewd[0] = wd;
      end else if (op_half(op)) begin
        ebe[0] = op_sgn(op) ? 4'b0100 : 4'b0011; ewd[0] = wd;
      end else begin
        ebe[0] = 4'(8 + (op_sgn(op) ? 4 : 0) + ai % 4);
        ewd[0] = {24'b0, wd[7:0]};
      end
    end
    erd = (f || op_st(op)) ? 32'h0 : exp_load(op, ai);

    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    k = 1;
    while (!resp_valid && k < 8) begin
      chk("ready_busy", 32'(req_ready), 32'd0);
      if (k <= nacc) begin
        chk("acc_we", 32'(mem_we), 32'(op_st(op)));
        chk("acc_be", 32'(mem_be), 32'(ebe[k-1]));
        chk("acc_a", mem_a, a & ~32'h3);
        if (op_st(op)) chk("acc_wd", mem_wd, ewd[k-1]);
      end
      @(negedge clk);
      k++;
    end
    chk("latency", k, lat);
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_ready", 32'(req_ready), 32'd0);
    chk("resp_fault", 32'(resp_fault), 32'(f));
    chk("resp_rdata", resp_rdata, erd);
    chk("resp_we", 32'(mem_we), 32'd0);
    if (f) chk("fault_be", 32'(mem_be), 32'd0);
    rd = resp_rdata;
    if (op_st(op) && !f) begin
      if (op_word(op)) begin
        for (int i = 0; i < 4; i++) ref_b[ai+i] = wd[8*i +: 8];
      end else if (op_half(op)) begin
        ref_b[ai]   = wd[7:0];
        ref_b[ai+1] = wd[15:8];
      end else begin
        ref_b[ai] = wd[7:0];
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [2:0]  op;
    logic [31:0] a, wd;
    bit          hold, prev_hold;

    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = init_word(i / 4);
      ref_b[i] = w[8*(i%4) +: 8];
    end
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_fault", 32'(resp_fault), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_a", mem_a, 32'h0);
    chk("rst_wd", mem_wd, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    do_req(T_STR, 32'h104, 32'hDEADBEEF, 1'b0, rd);
    do_req(T_LDR, 32'h104, 32'h0, 1'b0, rd);
    chk("ldr_word", rd, 32'hDEADBEEF);

    do_req(T_STRB, 32'h201, 32'h22, 1'b0, rd);
    do_req(T_LDRB, 32'h201, 32'h0, 1'b0, rd);
    chk("ldrb_22", rd, 32'h22);
    do_req(T_LDRSB, 32'h201, 32'h0, 1'b0, rd);
    chk("ldrsb_22", rd, 32'h22);
    do_req(T_STRB, 32'h201, 32'hA5, 1'b0, rd);
    do_req(T_LDRB, 32'h201, 32'h0, 1'b0, rd);
    chk("ldrb_a5", rd, 32'hA5);
    do_req(T_LDRSB, 32'h201, 32'h0, 1'b0, rd);
    chk("ldrsb_a5", rd, 32'hFFFFFFA5);

    do_req(T_STRH, 32'h302, 32'h8001, 1'b0, rd);
    do_req(T_LDRSH, 32'h302, 32'h0, 1'b0, rd);
    chk("ldrsh_split", rd, SPLIT ? 32'hFFFF8001 : 32'h0);
    do_req(T_LDRH, 32'h302, 32'h0, 1'b0, rd);
    chk("ldrh_split", rd, SPLIT ? 32'h00008001 : 32'h0);

    do_req(T_LDR, 32'h105, 32'h0, 1'b0, rd);
    do_req(T_LDRH, 32'h101, 32'h0, 1'b0, rd);

    do_req(T_STR, 32'h10, 32'h0BADF00D, 1'b1, rd);
    do_req(T_LDR, 32'h10, 32'h0, 1'b1, rd);
    chk("b2b_ldr", rd, 32'h0BADF00D);
    do_req(T_STRH, 32'h12, 32'h1234, 1'b1, rd);
    do_req(T_LDR, 32'h10, 32'h0, 1'b0, rd);
    @(negedge clk);
    chk("b2b_pulse", 32'(resp_valid), 32'd0);
    chk("b2b_idle", 32'(req_ready), 32'd1);

    // reset while a store sits in its access cycle
    req_valid = 1'b1;
    req_op    = T_STR;
    req_addr  = 32'h40;
    req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_acc_we_pre", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_acc_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_acc_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_acc_noresp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    do_req(T_LDR, 32'h40, 32'h0, 1'b0, rd);

    prev_hold = 1'b0;
    for (int it = 0; it < 300; it++) begin
      op = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (op_word(op)) a = a & ~32'h3;
        else if (op_half(op)) a = a & ~32'h1;
      end
      if (op_word(op) && a > 32'd1020) a = 32'd1020;
      wd   = $urandom;
      hold = 1'($urandom_range(0, 1));
      if (!prev_hold && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("gap_noresp", 32'(resp_valid), 32'd0);
        chk("gap_ready", 32'(req_ready), 32'd1);
      end
      do_req(op, a, wd, hold, rd);
      prev_hold = hold;
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("end_idle", 32'(req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
